// File: rtl/jpeg_pkg.sv
// Shared JPEG datapath definitions: block geometry, coefficient type and the
// zigzag scan table used by both the encoder reorder and the decoder inverse.
package jpeg_pkg;

  localparam int BLK_SZ = 64;
  localparam int IDX_W  = 6;
  localparam int COEF_W = 12;

  typedef logic signed [COEF_W-1:0] coef_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_SZ - 1);

  // ZZ[k] is the raster index (r*8+c) of the k-th coefficient in zigzag scan.
  localparam logic [IDX_W-1:0] ZZ [BLK_SZ] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  function automatic logic [IDX_W-1:0] zz_lookup(input logic [IDX_W-1:0] k);
    return ZZ[k];
  endfunction

endpackage

// File: rtl/jpeg_zigzag_reorder_if.sv
// Stream bundle around the zigzag reorder: raster-order input, zigzag-order
// output with block framing flags, plus the synchronous flush.
interface jpeg_zigzag_reorder_if #(
  parameter int DATA_W = 12
);
  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_sob;
  logic                     out_eob;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sob, out_eob
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sob, out_eob
  );

endinterface

// File: rtl/jpeg_zz_bank_ctrl.sv
// Ping-pong bookkeeping for the zigzag reorder: per-bank full flags plus
// independent write and read bank pointers and coefficient indices.
module jpeg_zz_bank_ctrl
  import jpeg_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic             in_ready,
  output logic             rd_avail,
  output logic             wr_bank,
  output logic             rd_bank,
  output logic [IDX_W-1:0] wr_idx,
  output logic [IDX_W-1:0] rd_idx
);

  logic [1:0] full;
  logic [1:0] full_nxt;
  logic       wr_last;
  logic       rd_last;

  assign wr_last  = (wr_idx == LAST_IDX);
  assign rd_last  = (rd_idx == LAST_IDX);
  assign in_ready = !full[wr_bank];
  assign rd_avail = full[rd_bank];

  // A completing write and a completing read never target the same bank:
  // writes only go to an empty bank and reads only drain a full one.
  always_comb begin
    full_nxt = full;
    if (wr_en && wr_last) full_nxt[wr_bank] = 1'b1;
    if (rd_en && rd_last) full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_idx  <= '0;
      rd_idx  <= '0;
    end else if (flush) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_idx  <= '0;
      rd_idx  <= '0;
    end else begin
      full <= full_nxt;
      if (wr_en) begin
        wr_idx <= wr_idx + IDX_W'(1);
        if (wr_last) wr_bank <= ~wr_bank;
      end
      if (rd_en) begin
        rd_idx <= rd_idx + IDX_W'(1);
        if (rd_last) rd_bank <= ~rd_bank;
      end
    end
  end

endmodule

// File: rtl/jpeg_zigzag_reorder.sv
// Raster-to-zigzag block reorder: two 64-entry banks written in raster order
// and read through the zigzag table into a single output register.
module jpeg_zigzag_reorder
  import jpeg_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int NBANK  = 2
)(
  input  logic                  clk,
  input  logic                  rst_n,
  jpeg_zigzag_reorder_if.slave  bus
);

  if (NBANK != 2) begin : g_nbank_check
    $error("jpeg_zigzag_reorder: NBANK must be 2");
  end

  logic             wr_en;
  logic             rd_en;
  logic             in_ready;
  logic             rd_avail;
  logic             wr_bank;
  logic             rd_bank;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  logic [DATA_W-1:0] mem [2][BLK_SZ];

  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_sob_q;
  logic              out_eob_q;

  assign wr_en = bus.in_valid && in_ready;
  // Load whenever the output register is free or being drained this cycle.
  assign rd_en = (!out_valid_q || bus.out_ready) && rd_avail;

  jpeg_zz_bank_ctrl u_bank_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (bus.flush),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .in_ready (in_ready),
    .rd_avail (rd_avail),
    .wr_bank  (wr_bank),
    .rd_bank  (rd_bank),
    .wr_idx   (wr_idx),
    .rd_idx   (rd_idx)
  );

  // Storage is plain flops without reset; validity lives in the full flags.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bank][wr_idx] <= bus.in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sob_q   <= 1'b0;
      out_eob_q   <= 1'b0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sob_q   <= 1'b0;
      out_eob_q   <= 1'b0;
    end else if (rd_en) begin
      out_valid_q <= 1'b1;
      out_data_q  <= mem[rd_bank][zz_lookup(rd_idx)];
      out_sob_q   <= (rd_idx == '0);
      out_eob_q   <= (rd_idx == LAST_IDX);
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
      out_sob_q   <= 1'b0;
      out_eob_q   <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sob   = out_sob_q;
  assign bus.out_eob   = out_eob_q;

endmodule

// File: tb/tb_jpeg_zigzag_reorder.sv
// Scoreboard bench for jpeg_zigzag_reorder: directed blocks push expected
// zigzag beats, a negedge monitor pops and compares each output transfer.
module tb_jpeg_zigzag_reorder;
  import jpeg_pkg::*;

  localparam int DW = 12;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sob;
    logic          eob;
  } exp_t;

  typedef logic [DW-1:0] blk_t [64];

  localparam int ZZ_REF [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  jpeg_zigzag_reorder_if #(.DATA_W(DW)) bus ();

  jpeg_zigzag_reorder #(.DATA_W(DW), .NBANK(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   beat_cnt = 0;
  int   last_beat_cyc = -1;
  int   bubble_cnt = 0;
  int   stall_cnt = 0;
  bit   gap_chk = 1'b0;
  bit   stall_chk = 1'b0;
  bit   rand_ready = 1'b0;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: every output transfer must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && !bus.flush && bus.out_valid && bus.out_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_out: actual data=%0d sob=%0b eob=%0b, required no output",
                 bus.out_data, bus.out_sob, bus.out_eob);
      end else begin
        e = sb.pop_front();
        if (bus.out_data !== e.data || bus.out_sob !== e.sob || bus.out_eob !== e.eob) begin
          n_err++;
          $display("FAIL beat%0d: actual data=%0d sob=%0b eob=%0b, required data=%0d sob=%0b eob=%0b",
                   beat_cnt, bus.out_data, bus.out_sob, bus.out_eob, e.data, e.sob, e.eob);
        end
      end
      if (gap_chk && last_beat_cyc >= 0 && cyc != last_beat_cyc + 1) bubble_cnt++;
      last_beat_cyc = cyc;
      beat_cnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic blk_t mk_block(input int base);
    blk_t b;
    for (int i = 0; i < 64; i++) b[i] = DW'(base + i);
    return b;
  endfunction

  task automatic push_block(input blk_t b);
    exp_t e;
    for (int k = 0; k < 64; k++) begin
      e.data = b[ZZ_REF[k]];
      e.sob  = (k == 0);
      e.eob  = (k == 63);
      sb.push_back(e);
    end
  endtask

  task automatic drive_coef(input logic [DW-1:0] d, input int idle);
    bit acc;
    int guard;
    bus.in_valid = 1'b0;
    repeat (idle) tick();
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    acc = 1'b0;
    guard = 0;
    while (!acc) begin
      @(negedge clk);
      acc = bus.in_ready;
      if (!acc && stall_chk) stall_cnt++;
      tick();
      guard++;
      if (!acc && guard > 2000) begin
        n_cmp++;
        n_err++;
        $display("FAIL in_accept_timeout: actual in_ready=0, required acceptance within 2000 cycles");
        break;
      end
    end
  endtask

  task automatic feed_block(input blk_t b, input int max_idle);
    for (int i = 0; i < 64; i++)
      drive_coef(b[i], (max_idle > 0) ? int'($urandom_range(0, max_idle)) : 0);
    bus.in_valid = 1'b0;
    push_block(b);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((sb.size() != 0 || bus.out_valid) && guard < 5000) begin
      tick();
      guard++;
    end
    if (guard >= 5000) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: actual pending=%0d, required 0", sb.size());
    end
  endtask

  initial begin
    blk_t b;
    int   b0;
    int   guard;

    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    #23;
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'd0);
    chk("rst_out_sob",   32'(bus.out_sob),   32'd0);
    chk("rst_out_eob",   32'(bus.out_eob),   32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Block of raster indices: output stream must be the zigzag table itself.
    bus.out_ready = 1'b1;
    feed_block(mk_block(0), 0);
    chk("lat_valid_at_T", 32'(bus.out_valid), 32'd0);
    tick();
    chk("lat_valid_T1", 32'(bus.out_valid), 32'd1);
    chk("lat_data_T1",  32'(bus.out_data),  32'd0);
    chk("lat_sob_T1",   32'(bus.out_sob),   32'd1);
    drain();

    // Four back-to-back blocks: no input stall, no output bubble.
    stall_cnt = 0; bubble_cnt = 0; last_beat_cyc = -1;
    stall_chk = 1'b1; gap_chk = 1'b1;
    for (int blk = 0; blk < 4; blk++) feed_block(mk_block(blk * 64), 0);
    drain();
    stall_chk = 1'b0; gap_chk = 1'b0;
    chk("b2b_in_stalls",   32'(stall_cnt),  32'd0);
    chk("b2b_out_bubbles", 32'(bubble_cnt), 32'd0);

    // Both banks filled with downstream stalled.
    bus.out_ready = 1'b0;
    feed_block(mk_block(256), 0);
    feed_block(mk_block(320), 0);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_data",  32'(bus.out_data),  32'd256);
      chk("hold_sob",   32'(bus.out_sob),   32'd1);
      chk("hold_eob",   32'(bus.out_eob),   32'd0);
    end
    bus.out_ready = 1'b1;
    repeat (62) @(posedge clk);
    #1;
    chk("release_in_ready_before_eob", 32'(bus.in_ready), 32'd0);
    tick();
    chk("release_in_ready_after_eob", 32'(bus.in_ready), 32'd1);
    drain();

    // Random backpressure and input gaps with arbitrary signed data.
    rand_ready = 1'b1;
    for (int blk = 0; blk < 20; blk++) begin
      for (int i = 0; i < 64; i++) b[i] = DW'($urandom);
      feed_block(b, 2);
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    bus.out_ready = 1'b1;
    drain();

    // Partial block discarded by flush.
    for (int i = 0; i < 30; i++) drive_coef(DW'(500 + i), 0);
    bus.in_valid = 1'b0;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_in_ready",  32'(bus.in_ready),  32'd1);
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    feed_block(mk_block(600), 0);
    drain();

    // Async reset in the middle of emitting a block.
    b0 = beat_cnt;
    feed_block(mk_block(700), 0);
    guard = 0;
    while (beat_cnt - b0 < 20 && guard < 500) begin
      tick();
      guard++;
    end
    chk("mid_reset_reached_beat20", 32'(beat_cnt - b0 >= 20), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("areset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("areset_in_ready",  32'(bus.in_ready),  32'd1);
    sb.delete();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset_idle", 32'(bus.out_valid), 32'd0);
    feed_block(mk_block(800), 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/jpeg_zigzag_reorder.md
Name: jpeg_zigzag_reorder

Overview:
- Block-reorder stage between the quantizer arithmetic and the run-length/Huffman encoder in the JPEG datapath.
- Accepts quantized 8x8 coefficients in raster order (row-major, index r*8+c).
- Emits the same block in JPEG zigzag order.
- Ping-pong register banks give full 1-coefficient/cycle throughput with valid/ready handshakes on both sides.

Parameters:
- DATA_W, 12, signed coefficient width in bits.
- NBANK, 2, number of 64-entry banks (ping-pong). Only the value 2 is supported; elaboration must fail on any other value.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear: discards all stored and partial blocks
- in_valid  in  1  input coefficient valid
- in_ready  out  1  block can accept a coefficient
- in_data  in  DATA_W  coefficient, raster order
- out_valid  out  1  output coefficient valid
- out_ready  in  1  downstream accepts the coefficient
- out_data  out  DATA_W  coefficient, zigzag order
- out_sob  out  1  high with the zigzag index 0 (DC) coefficient
- out_eob  out  1  high with the zigzag index 63 coefficient

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_data=0, out_sob=0, out_eob=0. Both banks are empty, wr_bank=0, rd_bank=0, wr_idx=0, rd_idx=0.
- Input transfer occurs when in_valid && in_ready. The coefficient is written to bank[wr_bank][wr_idx], then wr_idx increments.
- When wr_idx=63 is written:
  - bank[wr_bank] is marked full and wr_idx wraps to 0.
  - wr_bank toggles.
- in_ready = !full[wr_bank]. It is a combinational function of registered state only, with no dependency on in_valid.
- The output register loads when (!out_valid || out_ready) and full[rd_bank]:
  - out_data = bank[rd_bank][ZZ[rd_idx]]
  - out_sob = (rd_idx==0), out_eob = (rd_idx==63)
  - rd_idx increments.
- On loading rd_idx=63:
  - full[rd_bank] clears and rd_idx wraps to 0.
  - rd_bank toggles.
- If the output register is emptied (out_ready) and no bank is full, out_valid drops to 0 and the sob/eob flags drop to 0.
- out_data holds its last value while out_valid=0.
- Latency: the 64th input is accepted at edge T, the first output is loaded at edge T+1, and out_valid is high from T+1. Under continuous out_ready there are no bubbles, including at block boundaries when the next bank is already full.
- Simultaneous events:
  - Write completes into bank A while the read finishes bank B in the same cycle: both flag updates apply, and there is no stall.
  - Both banks full: in_ready=0 until the read of rd_bank completes. in_ready rises the cycle after the eob coefficient is loaded into the output register.
- Output stability: while out_valid && !out_ready, out_data, out_sob and out_eob must hold.
- flush (sync, highest priority after reset) returns all state to reset values on the next edge. Any output-register transfer in the flush cycle is lost.
- Async reset asserted mid-block behaves like flush, immediately and asynchronously. The partial block is dropped, with no partial emission after reset release.
- ZZ table uses the standard JPEG order: 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,12,19,26,33,40,48,41,34,27,20,13,6,7,14,21,28,35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63.
- Data is passed bit-exact; there is no arithmetic on coefficients.

Decomposition:
- Shared package jpeg_pkg holds:
  - BLK_SZ=64 and IDX_W=6
  - coef_t typedef (signed DATA_W)
  - the ZZ constant array (64 x IDX_W), also used by the decoder-side inverse zigzag.
- Natural sub-module: jpeg_zz_bank_ctrl, containing the ping-pong full flags, wr/rd bank pointers and indices. The top level holds the storage array and the output register.

Test Plan:
- One block with in_data=raster index (0..63) and out_ready=1 -> out_data sequence equals the ZZ table. out_sob on the first beat (data 0), out_eob on the 64th beat (data 63), first out_valid at edge T+1.
- Four back-to-back blocks with in_data=blk*64+idx, in_valid and out_ready held 1 -> in_ready never drops after the first block, 256 outputs with no bubble, and each block's zigzag order is correct.
- out_ready=0 while feeding 128 coefficients -> in_ready falls after coefficient 127 is accepted. Raising out_ready gives in_ready=1 the cycle after the first block's eob is loaded. The held output is stable during the stall.
- Random out_ready (50%) with random in_valid over 20 blocks -> scoreboard matches zigzag order exactly, and sob/eob appear once per 64 beats.
- 30 coefficients written, then flush=1 for one cycle, then a fresh block -> no output from the partial block, and the fresh block is emitted correctly starting with sob.
- rst_n pulsed low at mid-output (rd_idx=20) -> out_valid=0 immediately and in_ready=1. After release, a new block is emitted cleanly with no stale data.
